// File: rtl/receive_data.sv
// Feedback byte receiver: edge-detects UART bytes, validates type 01, updates feedback flags.
// Optional link watchdog enabled by defining RECV_TIMEOUT_EN.
module receive_data #(
  parameter int unsigned TIMEOUT_CYCLES = 153600,
  parameter int unsigned CNT_W          = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_out_bits,
  input  logic       data_out_valid,
  input  logic       script_mode,
  output logic [5:0] feedback,
  output logic       feedback_changed,
  output logic [7:0] fb_count,
  output logic       link_alive,
  output logic       overrun,
  output logic [7:0] leds
);

  typedef enum logic [1:0] {StIdle, StCheck, StUpdate} state_e;

  state_e     state;
  logic       valid_prev;
  logic       valid_straddle;
  logic [7:0] hold_reg;
  logic       overrun_q;
  logic       byte_det;
  logic       drop;

  if ((64'(1) << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

`ifdef RECV_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TimeoutLoad = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] timeout_cnt;
`endif

  // A level already high across reset release must not count as a new byte.
  assign byte_det = data_out_valid & ~valid_prev & ~valid_straddle;
  assign drop     = byte_det & (state != StIdle) & ~script_mode;
  assign overrun  = overrun_q | drop;
  assign leds     = {link_alive, overrun, feedback};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= StIdle;
      valid_prev       <= 1'b0;
      valid_straddle   <= data_out_valid;
      hold_reg         <= 8'h00;
      overrun_q        <= 1'b0;
      feedback         <= 6'h00;
      feedback_changed <= 1'b0;
      fb_count         <= 8'h00;
      link_alive       <= 1'b0;
`ifdef RECV_TIMEOUT_EN
      timeout_cnt      <= '0;
`endif
    end else begin
      valid_prev       <= data_out_valid;
      valid_straddle   <= 1'b0;
      feedback_changed <= 1'b0;
      if (drop) begin
        overrun_q <= 1'b1;
      end
      if (script_mode) begin
        state      <= StIdle;
        link_alive <= 1'b0;
`ifdef RECV_TIMEOUT_EN
        timeout_cnt <= '0;
`endif
      end else begin
`ifdef RECV_TIMEOUT_EN
        if (timeout_cnt != '0) begin
          timeout_cnt <= timeout_cnt - 1'b1;
          if (timeout_cnt == CNT_W'(1)) begin
            link_alive <= 1'b0;
          end
        end
`endif
        unique case (state)
          StIdle: begin
            if (byte_det) begin
              hold_reg <= data_out_bits;
              state    <= StCheck;
            end
          end
          StCheck: begin
            state <= (hold_reg[1:0] == 2'b01) ? StUpdate : StIdle;
          end
          StUpdate: begin
            // Assignments here override the watchdog decrement above.
            feedback         <= hold_reg[7:2];
            feedback_changed <= (hold_reg[7:2] != feedback);
            fb_count         <= fb_count + 8'd1;
            link_alive       <= 1'b1;
`ifdef RECV_TIMEOUT_EN
            timeout_cnt      <= TimeoutLoad;
`endif
            state            <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receive_data.sv
// Directed self-checking bench for receive_data; watchdog expectations follow RECV_TIMEOUT_EN.
module tb_receive_data;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_out_bits;
  logic       data_out_valid;
  logic       script_mode;
  logic [5:0] feedback;
  logic       feedback_changed;
  logic [7:0] fb_count;
  logic       link_alive;
  logic       overrun;
  logic [7:0] leds;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  receive_data #(
    .TIMEOUT_CYCLES(10),
    .CNT_W         (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .data_out_bits   (data_out_bits),
    .data_out_valid  (data_out_valid),
    .script_mode     (script_mode),
    .feedback        (feedback),
    .feedback_changed(feedback_changed),
    .fb_count        (fb_count),
    .link_alive      (link_alive),
    .overrun         (overrun),
    .leds            (leds)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns in cycle N+3, where the update is visible.
  task automatic send_byte(input logic [7:0] b);
    data_out_bits  = b;
    data_out_valid = 1'b1;
    tick();
    tick();
    data_out_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset          = 1'b0;
    script_mode    = 1'b0;
    data_out_bits  = 8'hA5;
    data_out_valid = 1'b1;
    tick();
    tick();
    check_eq("rst_feedback", 32'(feedback), 32'h00);
    check_eq("rst_changed", 32'(feedback_changed), 32'h0);
    check_eq("rst_count", 32'(fb_count), 32'h00);
    check_eq("rst_alive", 32'(link_alive), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    check_eq("rst_leds", 32'(leds), 32'h00);

    // Valid held high across reset release must not be taken as a byte.
    reset = 1'b1;
    repeat (5) tick();
    check_eq("straddle_count", 32'(fb_count), 32'h00);
    data_out_valid = 1'b0;
    tick();

    // A5: exact latency check.
    data_out_bits  = 8'hA5;
    data_out_valid = 1'b1;
    tick();
    tick();
    check_eq("lat_n2_feedback", 32'(feedback), 32'h00);
    check_eq("lat_n2_changed", 32'(feedback_changed), 32'h0);
    data_out_valid = 1'b0;
    tick();
    check_eq("a5_feedback", 32'(feedback), 32'h29);
    check_eq("a5_changed", 32'(feedback_changed), 32'h1);
    check_eq("a5_count", 32'(fb_count), 32'h01);
    check_eq("a5_alive", 32'(link_alive), 32'h1);
    check_eq("a5_leds", 32'(leds), 32'hA9);
    tick();
    check_eq("a5_pulse_end", 32'(feedback_changed), 32'h0);

    send_byte(8'hA5);
    check_eq("a5b_count", 32'(fb_count), 32'h02);
    check_eq("a5b_changed", 32'(feedback_changed), 32'h0);
    tick();

    send_byte(8'hA6);
    check_eq("a6_changed", 32'(feedback_changed), 32'h0);
    tick();
    check_eq("a6_feedback", 32'(feedback), 32'h29);
    check_eq("a6_count", 32'(fb_count), 32'h02);
    check_eq("a6_overrun", 32'(overrun), 32'h0);

    // Second edge two cycles after the first lands in UPDATE.
    data_out_bits  = 8'h05;
    data_out_valid = 1'b1;
    tick();
    data_out_valid = 1'b0;
    tick();
    data_out_bits  = 8'hFD;
    data_out_valid = 1'b1;
    #1;
    check_eq("ovr_same_cycle", 32'(overrun), 32'h1);
    tick();
    data_out_valid = 1'b0;
    check_eq("ovr_feedback", 32'(feedback), 32'h01);
    check_eq("ovr_changed", 32'(feedback_changed), 32'h1);
    check_eq("ovr_count", 32'(fb_count), 32'h03);
    repeat (4) tick();
    check_eq("ovr_sticky", 32'(overrun), 32'h1);
    check_eq("ovr_dropped", 32'(fb_count), 32'h03);

    script_mode = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      data_out_bits  = 8'hFD;
      data_out_valid = 1'b1;
      tick();
      data_out_valid = 1'b0;
      tick();
      tick();
    end
    check_eq("scr_feedback", 32'(feedback), 32'h01);
    check_eq("scr_count", 32'(fb_count), 32'h03);
    check_eq("scr_alive", 32'(link_alive), 32'h0);
    check_eq("scr_overrun", 32'(overrun), 32'h1);
    script_mode = 1'b0;
    tick();
    send_byte(8'hFD);
    check_eq("fd_feedback", 32'(feedback), 32'h3F);
    check_eq("fd_count", 32'(fb_count), 32'h04);
    check_eq("fd_changed", 32'(feedback_changed), 32'h1);
    check_eq("fd_leds", 32'(leds), 32'hFF);

    // Watchdog: alive through N+12, expiry at N+13 when enabled.
    repeat (9) tick();
    check_eq("wd_still_alive", 32'(link_alive), 32'h1);
    tick();
`ifdef RECV_TIMEOUT_EN
    check_eq("wd_expired", 32'(link_alive), 32'h0);
`else
    check_eq("wd_no_timeout", 32'(link_alive), 32'h1);
`endif
    repeat (3) tick();

    // script_mode rising during CHECK aborts the byte.
    data_out_bits  = 8'h09;
    data_out_valid = 1'b1;
    tick();
    script_mode    = 1'b1;
    data_out_valid = 1'b0;
    tick();
    tick();
    tick();
    check_eq("abort_chk_feedback", 32'(feedback), 32'h3F);
    check_eq("abort_chk_count", 32'(fb_count), 32'h04);
    script_mode = 1'b0;
    tick();

    // script_mode rising during UPDATE aborts the byte.
    data_out_bits  = 8'h09;
    data_out_valid = 1'b1;
    tick();
    data_out_valid = 1'b0;
    tick();
    script_mode = 1'b1;
    tick();
    check_eq("abort_upd_feedback", 32'(feedback), 32'h3F);
    check_eq("abort_upd_count", 32'(fb_count), 32'h04);
    check_eq("abort_upd_changed", 32'(feedback_changed), 32'h0);
    script_mode = 1'b0;
    tick();

    for (int i = 0; i < 251; i++) begin
      send_byte(8'h05);
    end
    check_eq("wrap_255", 32'(fb_count), 32'hFF);
    send_byte(8'h05);
    check_eq("wrap_0", 32'(fb_count), 32'h00);
    check_eq("wrap_overrun", 32'(overrun), 32'h1);
    tick();

    // Byte arriving in the reset cycle is lost.
    reset          = 1'b0;
    data_out_bits  = 8'h05;
    data_out_valid = 1'b1;
    tick();
    reset          = 1'b1;
    data_out_valid = 1'b0;
    repeat (4) tick();
    check_eq("rst2_count", 32'(fb_count), 32'h00);
    check_eq("rst2_feedback", 32'(feedback), 32'h00);
    check_eq("rst2_overrun", 32'(overrun), 32'h0);
    check_eq("rst2_alive", 32'(link_alive), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/receive_data.md
RECEIVE_DATA -- requirements
Module: receive_data

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 153600, is the number of clock cycles without a feedback byte before the link is declared lost (1 s at 16x9600 baud).
REQ-002 Parameter CNT_W, default 18, is the width of the timeout counter and SHALL satisfy 2^CNT_W > TIMEOUT_CYCLES.
REQ-003 clock  input  1  UART 16x baud clock, the same clock used by UART and ScriptMem.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 data_out_bits  input  8  byte from GenshinKitchen; meaningful only while data_out_valid=1.
REQ-006 data_out_valid  input  1  byte-available level from UART; may stay high for several cycles per byte.
REQ-007 script_mode  input  1  high while ScriptMem loads a script; received bytes belong to ScriptMem.
REQ-008 feedback  output  6  last accepted feedback flags, equal to byte bits[7:2].
REQ-009 feedback_changed  output  1  one-cycle pulse when feedback takes a new, different value.
REQ-010 fb_count  output  8  number of accepted feedback bytes, wraps modulo 256.
REQ-011 link_alive  output  1  a feedback byte has been accepted recently.
REQ-012 overrun  output  1  sticky flag: a byte arrived while the FSM was busy.
REQ-013 leds  output  8  {link_alive, overrun, feedback}.

Function
REQ-014 A byte SHALL be detected on the rising edge of data_out_valid: current=1 and the registered previous value=0.
REQ-015 The FSM SHALL have the states IDLE, CHECK and UPDATE.
REQ-016 In IDLE, a detected byte with script_mode=0 SHALL latch data_out_bits into hold_reg and move the FSM to CHECK.
REQ-017 In CHECK, hold_reg[1:0]==2'b01 SHALL move the FSM to UPDATE; any other value SHALL discard the byte and return the FSM to IDLE.
REQ-018 In UPDATE, the FSM SHALL perform the following actions and then return to IDLE: write feedback<=hold_reg[7:2], increment fb_count, reload the timeout counter.
REQ-019 feedback_changed SHALL pulse in the cycle after UPDATE only if the new feedback differs from the previous value.
REQ-020 Latency SHALL be fixed: edge detected in cycle N, feedback visible at cycle N+3, feedback_changed high only in cycle N+3.
REQ-021 A detected byte while the FSM is in CHECK or UPDATE SHALL be dropped and SHALL set overrun=1 for that same cycle and every later cycle until reset.
REQ-022 While script_mode=1, the block SHALL do the following:
- force the FSM to IDLE on the next edge;
- ignore all bytes and leave overrun unchanged;
- hold feedback and fb_count;
- clear link_alive and zero the timeout counter.
REQ-023 A script_mode rising edge during CHECK or UPDATE SHALL abort the pending byte with no feedback update.
REQ-024 When fb_count=255, an accepted byte SHALL give fb_count=0 with no flag.
REQ-025 A byte identical to the current feedback SHALL still increment fb_count and reload the timeout counter but SHALL NOT pulse feedback_changed.

Reset
REQ-026 With reset=0 at a clock edge, all of the following SHALL be 0: feedback, feedback_changed, fb_count, link_alive, overrun, hold_reg, timeout counter, valid-edge register. The FSM SHALL go to IDLE.
REQ-027 Reset SHALL take priority over every other event, including a byte arriving in the same cycle; that byte is lost.
REQ-028 A byte whose valid pulse straddles reset release SHALL NOT be detected if data_out_valid was already high when reset was released.

Configuration
REQ-029 The macro is RECV_TIMEOUT_EN.
REQ-030 With RECV_TIMEOUT_EN defined, the watchdog SHALL behave as follows:
- UPDATE loads the counter with TIMEOUT_CYCLES and sets link_alive=1;
- the counter decrements every cycle while non-zero;
- link_alive clears in the cycle the counter reaches 0.
REQ-031 With RECV_TIMEOUT_EN undefined, no timeout counter SHALL exist.
REQ-032 With RECV_TIMEOUT_EN undefined, link_alive SHALL be set by the first UPDATE and stay 1 until reset or script_mode=1.

Verification
REQ-033 Reset, then byte 8'hA5 (type 01): at N+3, feedback=6'h29, feedback_changed=1 for one cycle, fb_count=1, link_alive=1.
REQ-034 Byte 8'hA5 again after REQ-033: fb_count=2, feedback_changed stays 0.
REQ-035 Byte 8'hA6 (type 10): no change to feedback or fb_count, no pulse, overrun=0.
REQ-036 Two valid edges 2 cycles apart: the first byte is accepted, the second is dropped, overrun=1 until reset.
REQ-037 script_mode=1 during 3 bytes of 8'hFD: feedback and fb_count unchanged, link_alive=0; after script_mode falls, 8'hFD gives feedback=6'h3F.
REQ-038 With RECV_TIMEOUT_EN and TIMEOUT_CYCLES=10: link_alive=1 for exactly 10 cycles after UPDATE and then 0. Without the macro, link_alive stays 1.
